// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: operation codes,
// FSM states, default width and operation-decode helpers.
package mcycle_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_SMUL = 2'b00,
    OP_UMUL = 2'b01,
    OP_SDIV = 2'b10,
    OP_UDIV = 2'b11
  } mcycle_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COMPUTE = 2'b01,
    S_DONE    = 2'b10
  } mcycle_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_SDIV) || (op == OP_UDIV);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_SMUL) || (op == OP_SDIV);
  endfunction

endpackage

// File: rtl/mcycle_negate.sv
// Conditional two's-complement: passes a_i through, or negates it when en_i is set.
module mcycle_negate #(
  parameter int W = 32
) (
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o
);

  assign y_o = en_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per
// cycle on operand magnitudes, sign correction folded into the last step.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mcycle_state_e    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic             negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
  logic [WIDTH-1:0] res1_q, res1_d, res2_q, res2_d;
  logic             done_q;
  logic             busy_s;

  logic             in_div_s, in_sgn_s, op1_neg_s, op2_neg_s;
  logic [WIDTH-1:0] op1_mag_s, op2_mag_s;
  logic [WIDTH:0]   sum_s, rsh_s, trial_s;
  logic [WIDTH-1:0] hi_n_s, lo_n_s, quot_s, rem_s;
  logic [2*WIDTH-1:0] prod_s;

  assign in_div_s  = op_is_div(MCycleOp);
  assign in_sgn_s  = op_is_signed(MCycleOp);
  assign op1_neg_s = in_sgn_s & Operand1[WIDTH-1];
  assign op2_neg_s = in_sgn_s & Operand2[WIDTH-1];

  mcycle_negate #(.W(WIDTH)) u_neg_op1 (.en_i(op1_neg_s), .a_i(Operand1), .y_o(op1_mag_s));
  mcycle_negate #(.W(WIDTH)) u_neg_op2 (.en_i(op2_neg_s), .a_i(Operand2), .y_o(op2_mag_s));

  // One iteration: hi:lo is the partial product, or remainder:quotient for divide.
  always_comb begin
    sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    rsh_s   = {hi_q, lo_q[WIDTH-1]};
    trial_s = rsh_s - {1'b0, m_q};
    if (!op_is_div(op_q)) begin
      hi_n_s = sum_s[WIDTH:1];
      lo_n_s = {sum_s[0], lo_q[WIDTH-1:1]};
    end else if (!trial_s[WIDTH]) begin
      hi_n_s = trial_s[WIDTH-1:0];
      lo_n_s = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_n_s = rsh_s[WIDTH-1:0];
      lo_n_s = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  mcycle_negate #(.W(2*WIDTH)) u_neg_prod (.en_i(negq_q), .a_i({hi_n_s, lo_n_s}), .y_o(prod_s));
  mcycle_negate #(.W(WIDTH))   u_neg_quot (.en_i(negq_q), .a_i(lo_n_s), .y_o(quot_s));
  mcycle_negate #(.W(WIDTH))   u_neg_rem  (.en_i(negr_q), .a_i(hi_n_s), .y_o(rem_s));

  // Next-state, operand capture and result write-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    busy_s  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          busy_s  = 1'b1;
          state_d = S_COMPUTE;
          cnt_d   = '0;
          op_d    = MCycleOp;
          m_d     = in_div_s ? op2_mag_s : op1_mag_s;
          lo_d    = in_div_s ? op1_mag_s : op2_mag_s;
          hi_d    = '0;
          negq_d  = op1_neg_s ^ op2_neg_s;
          negr_d  = in_div_s & op1_neg_s;
          dz_d    = in_div_s & (Operand2 == '0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPUTE: begin
        busy_s = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        hi_d   = hi_n_s;
        lo_d   = lo_n_s;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          if (op_is_div(op_q)) begin
            res1_d = dz_q ? {WIDTH{1'b1}} : quot_s;
            res2_d = rem_s;
          end else begin
            res1_d = prod_s[WIDTH-1:0];
            res2_d = prod_s[2*WIDTH-1:WIDTH];
          end
        end else begin
          state_d = S_COMPUTE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      res1_q  <= '0;
      res2_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      done_q  <= (state_d == S_DONE);
    end
  end

  assign Busy    = busy_s & ~RESET;
  assign Done    = done_q;
  assign Result1 = res1_q;
  assign Result2 = res2_q;

endmodule

// File: doc/mcycle_unit.md
MCYCLE_UNIT -- requirements
Module: mcycle_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port Start, input, 1, an operation request.
REQ-005 The block SHALL have port MCycleOp, input, 2, the operation code: 00 signed multiply, 01 unsigned multiply, 10 signed divide, 11 unsigned divide.
REQ-006 The block SHALL have port Operand1, input, WIDTH, the multiplicand or dividend, driven from register file RD1.
REQ-007 The block SHALL have port Operand2, input, WIDTH, the multiplier or divisor, driven from register file RD2.
REQ-008 The block SHALL have port Result1, output, WIDTH, the product low word or the quotient.
REQ-009 The block SHALL have port Result2, output, WIDTH, the product high word or the remainder.
REQ-010 The block SHALL have port Busy, output, 1, the pipeline stall request.
REQ-011 The block SHALL have port Done, output, 1, a one-cycle completion pulse.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, COMPUTE, DONE.
REQ-013 In IDLE or DONE, a cycle with Start=1 SHALL be accepted: Operand1, Operand2 and MCycleOp are captured, the iteration counter is cleared, and the next state is COMPUTE.
REQ-014 In IDLE or DONE with Start=0, the next state SHALL be IDLE.
REQ-015 Busy SHALL be combinational: 1 when state=COMPUTE, or when state is IDLE/DONE and Start=1; otherwise 0.
REQ-016 In COMPUTE, each cycle SHALL perform exactly one iteration: shift-add for multiply, restore-subtract for divide; the counter increments per iteration.
REQ-017 After WIDTH iterations (counter = WIDTH-1 on that edge), Result1/Result2 SHALL be written and the next state SHALL be DONE.
REQ-018 Busy SHALL therefore be high for exactly WIDTH+1 consecutive cycles per operation (33 at default).
REQ-019 Done SHALL be 1 only in state DONE, a registered single-cycle pulse.
REQ-020 Start and operand changes during COMPUTE SHALL be ignored; no queueing.
REQ-021 Result1/Result2 SHALL hold their value until the next completed operation or reset.
REQ-022 Signed operations SHALL run on magnitudes and apply sign correction in the final iteration cycle, adding no extra latency.
REQ-023 For signed multiply, the product SHALL be the exact 2*WIDTH two's-complement result.
REQ-024 For signed divide, the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-025 For divide by zero (either signedness), the block SHALL return Result1 = all ones and Result2 = Operand1.
REQ-026 For signed overflow (most-negative value / -1), the block SHALL return Result1 = 0x80000000 and Result2 = 0.

Reset
REQ-027 RESET=1 at a clock edge SHALL force state IDLE, clear the counter, and set Result1=0, Result2=0, Done=0.
REQ-028 RESET SHALL take priority over Start and over any in-flight COMPUTE, aborting the operation with no result written.
REQ-029 While RESET=1, Busy SHALL read 0.
REQ-030 The first Start after RESET deasserts SHALL be accepted normally.

Structure
REQ-031 A shared package mcycle_pkg SHALL hold the MCycleOp encodings, the FSM state enum and the default WIDTH constant.
REQ-032 A single sub-module mcycle_negate (conditional two's-complement, parameterised width) SHALL be used for operand magnitude and result sign correction.
REQ-033 The FSM and shift/add datapath SHALL reside in mcycle_unit.

Verification
REQ-034 Unsigned multiply: 0xFFFFFFFF * 0xFFFFFFFF -> Result2=0xFFFFFFFE, Result1=0x00000001, Busy high 33 cycles, Done pulses once.
REQ-035 Signed multiply: 0xFFFFFFFD * 0x00000007 -> Result1=0xFFFFFFEB, Result2=0xFFFFFFFF.
REQ-036 Signed divide: 0xFFFFFFF9 / 0x00000002 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF; then 0x80000000 / 0xFFFFFFFF -> Result1=0x80000000, Result2=0.
REQ-037 Unsigned divide by zero: 0x00000064 / 0 -> Result1=0xFFFFFFFF, Result2=0x00000064.
REQ-038 Abort: RESET pulse on COMPUTE cycle 10 of a multiply -> next cycle Busy=0, Result1=Result2=0, Done never pulses; a following Start with 6*7 unsigned -> Result1=42 after 33 busy cycles.
REQ-039 Interference: Start with new operands toggled during COMPUTE -> results match the original operands; a Start in the DONE cycle is accepted, giving back-to-back operations with no IDLE gap.
